ws2812b_rx: RTL
===============

// Module: ws2812b_rx
// PURPOSE
//  Receive side of the WS2812B single-wire protocol: samples a serial LED data line, classifies high-pulse
//  widths into bits, assembles 24-bit GRB pixels MSB-first, and detects the reset/latch gap as end of frame.
//  Used for loopback self-check of the ws2812b driver output and as a frame sniffer in the LED-matrix build.
// PARAMETERS
//  NUM_PIXELS    64   pixels reported per frame (8x8 matrix); later pixels are not reported
//  MIN_HIGH      2    high pulse shorter than this (clk cycles) = glitch
//  BIT_THRESH    7    high pulse >= this = bit 1, else bit 0 (12 MHz: T0H~5, T1H~10)
//  MAX_HIGH      14   high pulse >= this = protocol error
//  RESET_CYCLES  600  continuous low >= this = latch/end of frame (50 us at 12 MHz)
// PORTS
//  clk            in   1   system clock
//  rst            in   1   synchronous reset, active high
//  din            in   1   WS2812B data line, asynchronous
//  o_pixel        out  24  last decoded pixel, GRB, G[23:16] R[15:8] B[7:0]
//  o_pixel_valid  out  1   1-cycle strobe: o_pixel/o_pixel_index valid
//  o_pixel_index  out  6   index of o_pixel within frame, 0..NUM_PIXELS-1
//  o_frame_done   out  1   1-cycle strobe on latch detection
//  o_frame_pixels out  7   complete pixels received in the finished frame, valid with o_frame_done
//  o_error        out  1   1-cycle strobe on glitch, overlong high, or partial pixel at latch
//  dout           out  1   forwarded data line (see CONFIGURATION)
// BEHAVIOUR
//  - din passes a 2-flop synchronizer -> din_s; all timing uses din_s; edges detected vs 1-cycle-delayed din_s.
//  - Reset: all outputs 0; shift reg, bit count (0..23), pixel count, high/low counters cleared; state SYNC.
//  - States: SYNC -> IDLE -> HIGH <-> LOW.
//    SYNC: wait for din_s low RESET_CYCLES consecutive cycles (any high restarts count) -> IDLE. No outputs.
//    IDLE: rising edge -> HIGH, high_cnt=1.
//    HIGH: high_cnt++ (saturate at MAX_HIGH). Falling edge -> classify, then LOW with low_cnt=1:
//      high_cnt < MIN_HIGH: o_error, discard partial pixel (bit count 0), pixel count kept.
//      high_cnt >= MAX_HIGH: o_error, discard partial pixel; din_s still high at MAX_HIGH -> o_error, SYNC.
//      else shift bit (high_cnt >= BIT_THRESH) into LSB, bit count++.
//    LOW: low_cnt++ (saturate). Rising edge before RESET_CYCLES -> HIGH. low_cnt == RESET_CYCLES -> latch.
//  - Pixel complete (24th bit): cycle after falling-edge detect, o_pixel = assembled word,
//    o_pixel_index = pixel count, o_pixel_valid=1 only if pixel count < NUM_PIXELS; pixel count++
//    (saturates at NUM_PIXELS+1 internally, o_frame_pixels saturates at NUM_PIXELS). o_pixel holds until next.
//  - Latch: o_frame_done=1 for 1 cycle, o_frame_pixels = min(pixel count, NUM_PIXELS); if bit count != 0
//    same cycle o_error=1 and partial bits dropped. Counters cleared; state IDLE.
//  - Latch with zero bits since last latch: no o_frame_done (low line idle is silent).
//  - Latency din pin edge -> o_pixel_valid: 3 cycles after the 24th falling edge (2 sync + 1 decode).
//  - Bit period not checked; low-phase length only matters for latch detection.
//  - rst mid-frame: immediate clear, returns to SYNC; frame in progress never reported.
// CONFIGURATION
//  WS2812B_RX_FORWARD_EN defined: mimics a chain LED - dout = 0 while pixel count < NUM_PIXELS,
//   then dout = din_s until latch (pulses beyond NUM_PIXELS passed through, 2-cycle delay); dout=0 in SYNC.
//  Not defined: dout tied 0; no forwarding logic built.
// TESTING
//  1 rst, din low 600 cycles, then 24 bits of 24'hFF0080 (1: high 10/low 5, 0: high 5/low 10)
//    -> o_pixel_valid once, o_pixel=24'hFF0080, o_pixel_index=0.
//  2 64 pixels i -> 24'h{i,~i,i} then low 600 -> 64 strobes, indices 0..63 in order, then
//    o_frame_done with o_frame_pixels=64, no o_error.
//  3 10 valid bits, 1-cycle high glitch, 24 bits 24'h123456, latch -> o_error at glitch, one pixel
//    24'h123456 index 0, o_frame_done o_frame_pixels=1.
//  4 1 pixel + 10 bits then low 600 -> o_frame_done o_frame_pixels=1 and o_error same cycle.
//  5 din high 20 cycles -> o_error, no pixel; next frame decoded only after 600-cycle low.
//  6 rst at bit 12 of pixel 3, resume mid-frame -> nothing reported until 600-cycle low;
//    with WS2812B_RX_FORWARD_EN, 66 pixels -> 64 strobes, pixels 64-65 appear on dout.

Source files
------------

// File: rtl/ws2812b_rx.sv
// WS2812B line receiver: pulse-width bit decode, 24-bit GRB pixel assembly, latch-gap frame detection.
// Optional chain-LED pass-through of pulses beyond NUM_PIXELS when WS2812B_RX_FORWARD_EN is defined.
module ws2812b_rx #(
  parameter int NUM_PIXELS   = 64,
  parameter int MIN_HIGH     = 2,
  parameter int BIT_THRESH   = 7,
  parameter int MAX_HIGH     = 14,
  parameter int RESET_CYCLES = 600
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        din,
  output logic [23:0] o_pixel,
  output logic        o_pixel_valid,
  output logic [5:0]  o_pixel_index,
  output logic        o_frame_done,
  output logic [6:0]  o_frame_pixels,
  output logic        o_error,
  output logic        dout
);

  localparam int HW = $clog2(MAX_HIGH + 1);
  localparam int LW = $clog2(RESET_CYCLES + 1);
  localparam logic [HW-1:0] MIN_H    = HW'(MIN_HIGH);
  localparam logic [HW-1:0] THRESH_H = HW'(BIT_THRESH);
  localparam logic [HW-1:0] MAX_H    = HW'(MAX_HIGH);
  localparam logic [LW-1:0] LATCH_AT = LW'(RESET_CYCLES - 1);
  localparam logic [6:0]    NP       = 7'(NUM_PIXELS);

  typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

  state_t          state, state_n;
  logic            din_m, din_s, din_d;
  logic [HW-1:0]   high_cnt, hc_n;
  logic [LW-1:0]   low_cnt, lc_n;
  logic [23:0]     shreg;
  logic [4:0]      bit_cnt;
  logic [6:0]      pix_cnt;
  logic            seen;
  logic            rise, fall;
  logic            shift, bit_v, err, discard, latch, to_sync;

  assign rise = din_s & ~din_d;
  assign fall = ~din_s & din_d;

  always_comb begin
    state_n = state;
    hc_n    = high_cnt;
    lc_n    = low_cnt;
    shift   = 1'b0;
    bit_v   = 1'b0;
    err     = 1'b0;
    discard = 1'b0;
    latch   = 1'b0;
    to_sync = 1'b0;
    case (state)
      SYNC: begin
        if (din_s) begin
          lc_n = '0;
        end else if (low_cnt == LATCH_AT) begin
          lc_n    = '0;
          state_n = IDLE;
        end else begin
          lc_n = low_cnt + LW'(1);
        end
      end
      IDLE: begin
        if (rise) begin
          state_n = HIGH;
          hc_n    = HW'(1);
        end
      end
      HIGH: begin
        if (fall) begin
          state_n = LOW;
          lc_n    = LW'(1);
          if (high_cnt < MIN_H || high_cnt >= MAX_H) begin
            err     = 1'b1;
            discard = 1'b1;
          end else begin
            shift = 1'b1;
            bit_v = (high_cnt >= THRESH_H);
          end
        end else if (high_cnt >= MAX_H) begin
          // line stuck high: framing is lost, resynchronise on a full latch gap
          err     = 1'b1;
          discard = 1'b1;
          to_sync = 1'b1;
          state_n = SYNC;
          lc_n    = '0;
        end else begin
          hc_n = high_cnt + HW'(1);
        end
      end
      LOW: begin
        if (rise) begin
          state_n = HIGH;
          hc_n    = HW'(1);
        end else if (low_cnt >= LATCH_AT) begin
          latch   = 1'b1;
          state_n = IDLE;
          lc_n    = '0;
        end else begin
          lc_n = low_cnt + LW'(1);
        end
      end
      default: state_n = SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= SYNC;
      din_m          <= 1'b0;
      din_s          <= 1'b0;
      din_d          <= 1'b0;
      high_cnt       <= '0;
      low_cnt        <= '0;
      shreg          <= '0;
      bit_cnt        <= '0;
      pix_cnt        <= '0;
      seen           <= 1'b0;
      o_pixel        <= '0;
      o_pixel_valid  <= 1'b0;
      o_pixel_index  <= '0;
      o_frame_done   <= 1'b0;
      o_frame_pixels <= '0;
      o_error        <= 1'b0;
    end else begin
      din_m         <= din;
      din_s         <= din_m;
      din_d         <= din_s;
      state         <= state_n;
      high_cnt      <= hc_n;
      low_cnt       <= lc_n;
      o_pixel_valid <= 1'b0;
      o_frame_done  <= 1'b0;
      o_error       <= err;

      if (shift) begin
        shreg <= {shreg[22:0], bit_v};
        seen  <= 1'b1;
        if (bit_cnt == 5'd23) begin
          bit_cnt       <= '0;
          o_pixel       <= {shreg[22:0], bit_v};
          o_pixel_index <= pix_cnt[5:0];
          o_pixel_valid <= (pix_cnt < NP);
          if (pix_cnt <= NP) pix_cnt <= pix_cnt + 7'd1;
        end else begin
          bit_cnt <= bit_cnt + 5'd1;
        end
      end else if (discard) begin
        bit_cnt <= '0;
      end

      if (to_sync) begin
        pix_cnt <= '0;
        seen    <= 1'b0;
      end

      if (latch) begin
        if (seen) begin
          o_frame_done   <= 1'b1;
          o_frame_pixels <= (pix_cnt > NP) ? NP : pix_cnt;
          o_error        <= (bit_cnt != '0);
        end
        bit_cnt <= '0;
        pix_cnt <= '0;
        seen    <= 1'b0;
        shreg   <= '0;
      end
    end
  end

`ifdef WS2812B_RX_FORWARD_EN
  assign dout = (state != SYNC) && (pix_cnt >= NP) && din_s;
`else
  assign dout = 1'b0;
`endif

endmodule
